// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential N x N integer matrix multiply C = A x B, one multiply-accumulate per clock.
// Latency: N^3 cycles from the start-sampling edge to the one-cycle done pulse; c updates only on that edge.
// Backpressure: none; start is ignored while busy. Define MATMUL_SIGNED_EN for two's-complement elements.
module matrix_mult_seq #(
  parameter int N = 3,
  parameter int W = 1,
  localparam int OW = 2 * W + $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N*N*W-1:0]  a,
  input  logic [N*N*W-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [N*N*OW-1:0] c
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_capture;
  logic                w_mac;
  logic                w_last;

  logic [N*N*W-1:0]    r_a;
  logic [N*N*W-1:0]    r_b;
  logic [OW-1:0]       r_acc;
  logic [IW-1:0]       r_i;
  logic [IW-1:0]       r_j;
  logic [IW-1:0]       r_k;
  logic [N*N*OW-1:0]   r_buf;
  logic [N*N*OW-1:0]   r_c;
  logic                r_done;

  logic [31:0]         w_a_base;
  logic [31:0]         w_b_base;
  logic [31:0]         w_c_base;
  logic [W-1:0]        w_a_elem;
  logic [W-1:0]        w_b_elem;
  logic [OW-1:0]       w_a_ext;
  logic [OW-1:0]       w_b_ext;
  logic [OW-1:0]       w_prod;
  logic [OW-1:0]       w_acc_nxt;
  logic [N*N*OW-1:0]   w_buf_upd;

  // Operand selection: A[i][k] and B[k][j] from the captured copies.
  assign w_a_base = (32'(r_i) * 32'(N) + 32'(r_k)) * 32'(W);
  assign w_b_base = (32'(r_k) * 32'(N) + 32'(r_j)) * 32'(W);
  assign w_c_base = (32'(r_i) * 32'(N) + 32'(r_j)) * 32'(OW);
  assign w_a_elem = r_a[w_a_base +: W];
  assign w_b_elem = r_b[w_b_base +: W];

`ifdef MATMUL_SIGNED_EN
  assign w_a_ext = {{(OW - W){w_a_elem[W-1]}}, w_a_elem};
  assign w_b_ext = {{(OW - W){w_b_elem[W-1]}}, w_b_elem};
`else
  assign w_a_ext = {{(OW - W){1'b0}}, w_a_elem};
  assign w_b_ext = {{(OW - W){1'b0}}, w_b_elem};
`endif

  // OW-bit product is exact in both modes, so truncation never loses information.
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_acc_nxt = r_acc + w_prod;

  // Result buffer with the current (i,j) element replaced by the finished dot product.
  always_comb begin
    w_buf_upd = r_buf;
    w_buf_upd[w_c_base +: OW] = w_acc_nxt;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_mac       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_mac = 1'b1;
        if (r_i == LAST && r_j == LAST && r_k == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, MAC, index walk, result buffer and atomic c update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_buf  <= '0;
      r_c    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_capture) begin
        r_a   <= a;
        r_b   <= b;
        r_acc <= '0;
        r_i   <= '0;
        r_j   <= '0;
        r_k   <= '0;
      end else if (w_mac) begin
        if (r_k != LAST) begin
          r_acc <= w_acc_nxt;
          r_k   <= r_k + IW'(1);
        end else begin
          r_buf <= w_buf_upd;
          r_acc <= '0;
          r_k   <= '0;
          if (r_j == LAST) begin
            r_j <= '0;
            r_i <= (r_i == LAST) ? '0 : r_i + IW'(1);
          end else begin
            r_j <= r_j + IW'(1);
          end
          if (w_last) r_c <= w_buf_upd;
        end
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign c    = r_c;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Bench for matrix_mult_seq: three instances (3x3/W1, 4x4/W8, 2x2/W4) driven from one initial block.
// Expected results come from a reference model and are queued per instance, popped on done.
// Signedness of the model follows MATMUL_SIGNED_EN, matching the build of the design.
module tb_matrix_mult_seq;

  localparam int N3 = 3, W3 = 1, OW3 = 2 * W3 + $clog2(N3);
  localparam int N4 = 4, W4 = 8, OW4 = 2 * W4 + $clog2(N4);
  localparam int N2 = 2, W2 = 4, OW2 = 2 * W2 + $clog2(N2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic                  s3 = 1'b0, s4 = 1'b0, s2 = 1'b0;
  logic [N3*N3*W3-1:0]   a3 = '0, b3 = '0;
  logic [N4*N4*W4-1:0]   a4 = '0, b4 = '0;
  logic [N2*N2*W2-1:0]   a2 = '0, b2 = '0;
  logic                  busy3, done3, busy4, done4, busy2, done2;
  logic [N3*N3*OW3-1:0]  c3;
  logic [N4*N4*OW4-1:0]  c4;
  logic [N2*N2*OW2-1:0]  c2;

  logic [N3*N3*OW3-1:0]  q3[$];
  logic [N4*N4*OW4-1:0]  q4[$];
  logic [N2*N2*OW2-1:0]  q2[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_mult_seq #(.N(N3), .W(W3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(s3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .c(c3));

  matrix_mult_seq #(.N(N4), .W(W4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .c(c4));

  matrix_mult_seq #(.N(N2), .W(W2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .c(c2));

  function automatic longint elem(logic [127:0] v, int idx, int w);
    longint e = 0;
    for (int t = 0; t < w; t++) e[t] = v[idx * w + t];
`ifdef MATMUL_SIGNED_EN
    if (e[w-1]) e = e - (longint'(1) << w);
`endif
    return e;
  endfunction

  function automatic logic [511:0] model(int n, int w, int ow, logic [127:0] av, logic [127:0] bv);
    logic [511:0] r = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        longint s = 0;
        for (int k = 0; k < n; k++) s += elem(av, i * n + k, w) * elem(bv, k * n + j, w);
        for (int t = 0; t < ow; t++) r[(i * n + j) * ow + t] = s[t];
      end
    end
    return r;
  endfunction

  task automatic push3();
    logic [511:0] m;
    m = model(N3, W3, OW3, 128'(a3), 128'(b3));
    q3.push_back(m[N3*N3*OW3-1:0]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy3: got %b expected 0", busy3); end
    checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL reset_done3: got %b expected 0", done3); end
    checks++; if (c3 !== '0) begin errors++; $display("FAIL reset_c3: got %h expected 0", c3); end
    checks++; if (c4 !== '0 || busy4 !== 1'b0) begin errors++; $display("FAIL reset_dut4: c=%h busy=%b expected 0/0", c4, busy4); end
    checks++; if (c2 !== '0 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_dut2: c=%h busy=%b expected 0/0", c2, busy2); end
    s3 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [N3*N3*OW3-1:0] exp;
    int lat, busy_cnt;
    bit got;
    a3 = 9'h1D5; b3 = 9'h0F3; s3 = 1'b1;
    push3();
    @(posedge clk); #1;
    s3 = 1'b0;
    busy_cnt = busy3 ? 1 : 0;
    lat = 0; got = 0;
    for (int cyc = 0; cyc < 60 && !got; cyc++) begin
      @(posedge clk); #1;
      lat++;
      if (done3) got = 1;
      else if (busy3) busy_cnt++;
    end
    exp = q3.pop_front();
    checks++; if (!got) begin errors++; $display("FAIL basic_timeout: no done within 60 cycles"); end
    checks++; if (lat != 27) begin errors++; $display("FAIL basic_latency: got %0d expected 27", lat); end
    checks++; if (busy_cnt != 27) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 27", busy_cnt); end
    checks++; if (c3 !== exp) begin errors++; $display("FAIL basic_c_model: got %h expected %h", c3, exp); end
    checks++; if (c3 !== 36'h132110022) begin errors++; $display("FAIL basic_c_const: got %h expected 132110022", c3); end
    @(posedge clk); #1;
    checks++; if (done3 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: done=%b busy=%b expected 0/0", done3, busy3); end
  endtask

  task automatic test_max();
    logic [511:0] m;
    logic [N4*N4*OW4-1:0] exp;
    logic [OW4-1:0] exp_e;
    int lat;
    bit got;
`ifdef MATMUL_SIGNED_EN
    exp_e = 18'd4;
`else
    exp_e = 18'h3F804;
`endif
    a4 = '1; b4 = '1; s4 = 1'b1;
    m = model(N4, W4, OW4, 128'(a4), 128'(b4));
    q4.push_back(m[N4*N4*OW4-1:0]);
    @(posedge clk); #1;
    s4 = 1'b0;
    lat = 0; got = 0;
    for (int cyc = 0; cyc < 120 && !got; cyc++) begin
      @(posedge clk); #1;
      lat++;
      if (done4) got = 1;
    end
    exp = q4.pop_front();
    checks++; if (!got || lat != 64) begin errors++; $display("FAIL max_latency: got %0d (done=%0d) expected 64", lat, got); end
    checks++; if (c4 !== exp) begin errors++; $display("FAIL max_c_model: got %h expected %h", c4, exp); end
    for (int e = 0; e < N4 * N4; e++) begin
      checks++;
      if (c4[e*OW4 +: OW4] !== exp_e) begin errors++; $display("FAIL max_elem%0d: got %h expected %h", e, c4[e*OW4 +: OW4], exp_e); end
    end
  endtask

  task automatic test_signed();
    logic [511:0] m;
    logic [N2*N2*OW2-1:0] exp;
    bit got;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin a2 = {4{4'h8}}; b2 = {4{4'h8}}; end
      else begin a2 = 16'h8F37; b2 = 16'hC29E; end
      s2 = 1'b1;
      m = model(N2, W2, OW2, 128'(a2), 128'(b2));
      q2.push_back(m[N2*N2*OW2-1:0]);
      @(posedge clk); #1;
      s2 = 1'b0;
      got = 0;
      for (int cyc = 0; cyc < 30 && !got; cyc++) begin
        @(posedge clk); #1;
        if (done2) got = 1;
      end
      exp = q2.pop_front();
      checks++; if (!got) begin errors++; $display("FAIL signed_timeout pass %0d: no done", pass); end
      checks++; if (c2 !== exp) begin errors++; $display("FAIL signed_c_model pass %0d: got %h expected %h", pass, c2, exp); end
      if (pass == 0) begin
        for (int e = 0; e < N2 * N2; e++) begin
          checks++;
          if (c2[e*OW2 +: OW2] !== 9'h080) begin errors++; $display("FAIL signed_elem%0d: got %h expected 080", e, c2[e*OW2 +: OW2]); end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [N3*N3*W3-1:0] ops_a[3];
    logic [N3*N3*W3-1:0] ops_b[3];
    logic [N3*N3*OW3-1:0] exp, held;
    int n, cyc, last_done;
    bit stable_ok;
    ops_a[0] = 9'h1FF; ops_b[0] = 9'h1FF;
    ops_a[1] = 9'h0A5; ops_b[1] = 9'h15A;
    ops_a[2] = 9'h123; ops_b[2] = 9'h0F0;
    a3 = ops_a[0]; b3 = ops_b[0]; s3 = 1'b1;
    push3();
    held = c3;
    @(posedge clk); #1;
    n = 0; cyc = 0; last_done = 0; stable_ok = 1;
    while (n < 3 && cyc < 200) begin
      if (c3 !== held) stable_ok = 0;
      @(posedge clk); #1;
      cyc++;
      if (done3) begin
        exp = q3.pop_front();
        checks++; if (c3 !== exp) begin errors++; $display("FAIL b2b_c run %0d: got %h expected %h", n, c3, exp); end
        checks++;
        if (cyc - last_done != ((n == 0) ? 27 : 28)) begin
          errors++; $display("FAIL b2b_spacing run %0d: got %0d expected %0d", n, cyc - last_done, (n == 0) ? 27 : 28);
        end
        last_done = cyc;
        held = c3;
        n++;
        if (n < 3) begin a3 = ops_a[n]; b3 = ops_b[n]; push3(); end
        else s3 = 1'b0;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_count: got %0d done pulses expected 3", n); end
    checks++; if (!stable_ok) begin errors++; $display("FAIL b2b_c_stable: c changed between done pulses"); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: busy=%b expected 0", busy3); end
    q3.delete();
  endtask

  task automatic test_start_ignored();
    logic [N3*N3*OW3-1:0] exp;
    int ndone, lat;
    a3 = 9'h0B6; b3 = 9'h16D; s3 = 1'b1;
    push3();
    @(posedge clk); #1;
    s3 = 1'b0;
    ndone = 0; lat = 0;
    exp = q3.pop_front();
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(posedge clk); #1;
      if (done3) begin
        ndone++;
        if (ndone == 1) begin
          lat = cyc;
          checks++; if (c3 !== exp) begin errors++; $display("FAIL ignore_c: got %h expected %h", c3, exp); end
        end
      end
      if (cyc >= 3 && cyc <= 8) begin
        s3 = 1'b1;
        a3 = 9'($urandom);
        b3 = 9'($urandom);
      end else begin
        s3 = 1'b0;
      end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    checks++; if (lat != 27) begin errors++; $display("FAIL ignore_latency: got %0d expected 27", lat); end
  endtask

  task automatic test_reset_abort();
    logic [N3*N3*OW3-1:0] exp;
    bit zero_ok, spurious, got;
    int lat;
    a3 = 9'h1AB; b3 = 9'h0CD; s3 = 1'b1;
    @(posedge clk); #1;
    s3 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (busy3 !== 1'b0 || done3 !== 1'b0) begin errors++; $display("FAIL abort_state: busy=%b done=%b expected 0/0", busy3, done3); end
    checks++; if (c3 !== '0) begin errors++; $display("FAIL abort_c_cleared: got %h expected 0", c3); end
    zero_ok = 1; spurious = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (done3) spurious = 1;
      if (c3 !== '0) zero_ok = 0;
    end
    checks++; if (spurious) begin errors++; $display("FAIL abort_no_done: done seen after aborted run"); end
    a3 = 9'h0F7; b3 = 9'h1E9; s3 = 1'b1;
    push3();
    @(posedge clk); #1;
    s3 = 1'b0;
    lat = 0; got = 0;
    for (int cyc = 0; cyc < 60 && !got; cyc++) begin
      if (c3 !== '0) zero_ok = 0;
      @(posedge clk); #1;
      lat++;
      if (done3) got = 1;
    end
    exp = q3.pop_front();
    checks++; if (!zero_ok) begin errors++; $display("FAIL abort_c_held_zero: c nonzero before new completion"); end
    checks++; if (!got || lat != 27) begin errors++; $display("FAIL abort_rerun_latency: got %0d (done=%0d) expected 27", lat, got); end
    checks++; if (c3 !== exp) begin errors++; $display("FAIL abort_rerun_c: got %h expected %h", c3, exp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_signed();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
